// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage.
// Holds the bus widths, the stall vector width, the Stop/NoStop levels, the
// mem_op load encodings and the packed layout of the EX->MEM bus.
// Also holds one helper that classifies the held instruction as a load.
package mem_stage_pkg;

  localparam int EX_TO_MEM_WD = 80;
  localparam int MEM_TO_WB_WD = 70;
  localparam int MEM_TO_ID_FW = 38;
  localparam int STALL_BUS    = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Load-width encodings carried in the mem_op field.
  localparam logic [3:0] MEM_OP_LW  = 4'b1111;
  localparam logic [3:0] MEM_OP_LB  = 4'b0001;
  localparam logic [3:0] MEM_OP_LBU = 4'b0010;
  localparam logic [3:0] MEM_OP_LH  = 4'b0011;
  localparam logic [3:0] MEM_OP_LHU = 4'b0100;

  // Field order matches the bit positions of ex_to_mem_bus, MSB first.
  typedef struct packed {
    logic [3:0]  mem_op;       // [79:76]
    logic [31:0] pc;           // [75:44]
    logic        data_ram_en;  // [43]
    logic [3:0]  data_ram_wen; // [42:39]
    logic        sel_rf_res;   // [38]
    logic        rf_we;        // [37]
    logic [4:0]  rf_waddr;     // [36:32]
    logic [31:0] ex_result;    // [31:0]
  } ex_to_mem_t;

  // A load enables the data RAM, writes none of its bytes, and takes its
  // register-file result from memory.
  function automatic logic is_load_f(input ex_to_mem_t b);
    return b.data_ram_en && (b.data_ram_wen == 4'b0000) && b.sel_rf_res;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load-data extraction for the MEM stage.
// Ports:
//   mem_op_i    : load width/sign encoding
//   is_load_i   : held instruction is a load
//   ex_result_i : ALU result; its low bits are also the byte address
//   rdata_i     : 32-bit word read from the data memory
//   rf_wdata_o  : value to write back to the register file
module load_align
  import mem_stage_pkg::*;
(
  input  logic [3:0]  mem_op_i,
  input  logic        is_load_i,
  input  logic [31:0] ex_result_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rf_wdata_o
);

  logic [7:0]  byte_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign byte_lane[gi] = rdata_i[8*gi +: 8];
  end

  assign byte_sel = byte_lane[ex_result_i[1:0]];
  // Halfword offset ignores address bit 0; misaligned halfwords are not trapped.
  assign half_sel = ex_result_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    load_data = rdata_i;  // LW and any unrecognised encoding
    case (mem_op_i)
      MEM_OP_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: load_data = {24'h0, byte_sel};
      MEM_OP_LH:  load_data = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LHU: load_data = {16'h0, half_sel};
      default:    load_data = rdata_i;
    endcase
  end

  assign rf_wdata_o = is_load_i ? load_data : ex_result_i;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage.
// Registers the EX->MEM bus, extracts load data from the synchronous data
// SRAM, and keeps the SRAM word in a side buffer while writeback is stalled
// so the value survives the SRAM output changing underneath it.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   stall           : stall vector; bit 3 = this stage, bit 4 = writeback
//   ex_to_mem_bus   : instruction from EX
//   data_sram_rdata : SRAM read data, valid the cycle after the EX request
//   mem_to_wb_bus   : {pc, rf_we, rf_waddr, rf_wdata} to writeback
//   mem_to_id_bus   : {rf_we, rf_waddr, rf_wdata} forwarding to decode
//   mem_is_load     : held instruction is a load (hazard detection)
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS-1:0]    stall,
  input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  input  logic [31:0]             data_sram_rdata,
  output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
  output logic [MEM_TO_ID_FW-1:0] mem_to_id_bus,
  output logic                    mem_is_load
);

  ex_to_mem_t  bus_q, bus_d;
  logic [31:0] rbuf_q, rbuf_d;
  logic        rbuf_valid_q, rbuf_valid_d;
  logic        is_load;
  logic [31:0] load_rdata;
  logic [31:0] rf_wdata;

  // Only stall bits 3 and 4 concern this stage.
  logic stall_unused;
  assign stall_unused = &{1'b0, stall[5], stall[2:0]};

  // Input register: a stop here with writeback running inserts a bubble.
  always_comb begin
    bus_d = bus_q;
    if (stall[3] == STOP && stall[4] == NO_STOP) begin
      bus_d = '0;
    end else if (stall[3] == NO_STOP) begin
      bus_d = ex_to_mem_bus;
    end
  end

  // Read-data buffer: capture the SRAM word on the first stalled cycle of a
  // load; drop it as soon as the instruction moves on or is replaced.
  always_comb begin
    rbuf_d       = rbuf_q;
    rbuf_valid_d = rbuf_valid_q;
    if (stall[3] == NO_STOP || stall[4] == NO_STOP) begin
      rbuf_valid_d = 1'b0;
    end else if (!rbuf_valid_q && is_load) begin
      rbuf_d       = data_sram_rdata;
      rbuf_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_q        <= '0;
      rbuf_q       <= '0;
      rbuf_valid_q <= 1'b0;
    end else begin
      bus_q        <= bus_d;
      rbuf_q       <= rbuf_d;
      rbuf_valid_q <= rbuf_valid_d;
    end
  end

  assign is_load    = is_load_f(bus_q);
  assign load_rdata = rbuf_valid_q ? rbuf_q : data_sram_rdata;

  load_align u_load_align (
    .mem_op_i    (bus_q.mem_op),
    .is_load_i   (is_load),
    .ex_result_i (bus_q.ex_result),
    .rdata_i     (load_rdata),
    .rf_wdata_o  (rf_wdata)
  );

  // An all-zero bubble carries rf_we=0, so nothing forwards from it.
  assign mem_to_wb_bus = {bus_q.pc, bus_q.rf_we, bus_q.rf_waddr, rf_wdata};
  assign mem_to_id_bus = {bus_q.rf_we, bus_q.rf_waddr, rf_wdata};
  assign mem_is_load   = is_load;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage. Inputs change 1 time unit after the
// rising edge; outputs are checked after a further settle delay.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [79:0] ex_to_mem_bus;
  logic [31:0] data_sram_rdata;
  logic [69:0] mem_to_wb_bus;
  logic [37:0] mem_to_id_bus;
  logic        mem_is_load;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .data_sram_rdata (data_sram_rdata),
    .mem_to_wb_bus   (mem_to_wb_bus),
    .mem_to_id_bus   (mem_to_id_bus),
    .mem_is_load     (mem_is_load)
  );

  function automatic logic [79:0] mk_load(input logic [3:0] op, input logic [31:0] pc,
                                          input logic [4:0] wa, input logic [31:0] addr);
    return {op, pc, 1'b1, 4'b0000, 1'b1, 1'b1, wa, addr};
  endfunction

  function automatic logic [79:0] mk_alu(input logic [31:0] pc, input logic [4:0] wa,
                                         input logic [31:0] res);
    return {4'b0000, pc, 1'b0, 4'b0000, 1'b0, 1'b1, wa, res};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("vec %0d %s observed=%h expected=%h", vectors, tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1;
    stall = 6'b000000;
    ex_to_mem_bus = '0;
    data_sram_rdata = 32'h5555_AAAA;

    // Reset
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("reset_wb", 70'(mem_to_wb_bus), 70'h0);
    chk("reset_id", 70'(mem_to_id_bus), 70'h0);
    chk("reset_isload", 70'(mem_is_load), 70'h0);

    // LW, no stall
    ex_to_mem_bus = mk_load(MEM_OP_LW, 32'h0000_0100, 5'd3, 32'h0000_1000);
    cycle();
    ex_to_mem_bus = '0;
    data_sram_rdata = 32'h8081_7F01;
    #1;
    chk("lw_wdata", 70'(mem_to_wb_bus[31:0]), 70'h8081_7F01);
    chk("lw_we", 70'(mem_to_wb_bus[37]), 70'h1);
    chk("lw_waddr", 70'(mem_to_wb_bus[36:32]), 70'd3);
    chk("lw_pc", 70'(mem_to_wb_bus[69:38]), 70'h100);
    chk("lw_isload", 70'(mem_is_load), 70'h1);
    chk("lw_id", 70'(mem_to_id_bus), 70'({1'b1, 5'd3, 32'h8081_7F01}));

    // LB / LBU at offset 3
    ex_to_mem_bus = mk_load(MEM_OP_LB, 32'h104, 5'd4, 32'h0000_1003);
    cycle();
    data_sram_rdata = 32'h8012_3456;
    #1;
    chk("lb_off3", 70'(mem_to_wb_bus[31:0]), 70'hFFFF_FF80);
    ex_to_mem_bus = mk_load(MEM_OP_LBU, 32'h108, 5'd4, 32'h0000_1003);
    cycle();
    #1;
    chk("lbu_off3", 70'(mem_to_wb_bus[31:0]), 70'h0000_0080);
    // LB offset 1, positive byte
    ex_to_mem_bus = mk_load(MEM_OP_LB, 32'h10C, 5'd4, 32'h0000_1001);
    cycle();
    data_sram_rdata = 32'hAB12_7FCD;
    #1;
    chk("lb_off1", 70'(mem_to_wb_bus[31:0]), 70'h0000_007F);

    // LH / LHU at offset 2
    ex_to_mem_bus = mk_load(MEM_OP_LH, 32'h110, 5'd6, 32'h0000_1002);
    cycle();
    data_sram_rdata = 32'h8001_1234;
    #1;
    chk("lh_off2", 70'(mem_to_wb_bus[31:0]), 70'hFFFF_8001);
    ex_to_mem_bus = mk_load(MEM_OP_LHU, 32'h114, 5'd6, 32'h0000_1002);
    cycle();
    #1;
    chk("lhu_off2", 70'(mem_to_wb_bus[31:0]), 70'h0000_8001);
    // LH offset 0 (bit 0 set is ignored -> still low half)
    ex_to_mem_bus = mk_load(MEM_OP_LH, 32'h118, 5'd6, 32'h0000_1001);
    cycle();
    #1;
    chk("lh_off1", 70'(mem_to_wb_bus[31:0]), 70'h0000_1234);
    // Unknown mem_op on a load behaves as LW
    ex_to_mem_bus = mk_load(4'b0111, 32'h11C, 5'd6, 32'h0000_1003);
    cycle();
    #1;
    chk("unk_op_lw", 70'(mem_to_wb_bus[31:0]), 70'h8001_1234);

    // Stall hold: writeback stalled 3 cycles while SRAM output changes
    ex_to_mem_bus = mk_load(MEM_OP_LW, 32'h200, 5'd7, 32'h0000_2000);
    cycle();
    ex_to_mem_bus = mk_alu(32'h999, 5'd9, 32'h0000_0999);
    data_sram_rdata = 32'h1234_5678;
    stall = 6'b011111;
    #1;
    chk("hold_c0", 70'(mem_to_wb_bus[31:0]), 70'h1234_5678);
    for (int i = 1; i <= 2; i++) begin
      cycle();
      data_sram_rdata = 32'hDEAD_BEEF;
      #1;
      chk($sformatf("hold_c%0d", i), 70'(mem_to_wb_bus[31:0]), 70'h1234_5678);
      chk($sformatf("hold_valid_c%0d", i), 70'(dut.rbuf_valid_q), 70'h1);
      chk($sformatf("hold_pc_c%0d", i), 70'(mem_to_wb_bus[69:38]), 70'h200);
    end
    // Release: next load sees live SRAM data again
    ex_to_mem_bus = mk_load(MEM_OP_LW, 32'h204, 5'd8, 32'h0000_2004);
    cycle();
    stall = 6'b000000;
    cycle();
    ex_to_mem_bus = '0;
    #1;
    chk("release_valid", 70'(dut.rbuf_valid_q), 70'h0);
    chk("release_wdata", 70'(mem_to_wb_bus[31:0]), 70'hDEAD_BEEF);
    chk("release_pc", 70'(mem_to_wb_bus[69:38]), 70'h204);

    // Bubble: this stage stops, writeback proceeds
    ex_to_mem_bus = mk_alu(32'h300, 5'd5, 32'h0000_0011);
    cycle();
    stall = 6'b001111;
    cycle();
    stall = 6'b000000;
    ex_to_mem_bus = '0;
    #1;
    chk("bubble_wb", 70'(mem_to_wb_bus), 70'h0);
    chk("bubble_id_we", 70'(mem_to_id_bus[37]), 70'h0);

    // Non-load pass-through
    ex_to_mem_bus = mk_alu(32'h400, 5'd5, 32'h0000_002A);
    cycle();
    ex_to_mem_bus = '0;
    data_sram_rdata = 32'hFFFF_FFFF;
    #1;
    chk("alu_waddr", 70'(mem_to_wb_bus[36:32]), 70'd5);
    chk("alu_wdata", 70'(mem_to_wb_bus[31:0]), 70'h2A);
    chk("alu_isload", 70'(mem_is_load), 70'h0);
    chk("alu_id", 70'(mem_to_id_bus), 70'({1'b1, 5'd5, 32'h0000_002A}));

    // Reset mid-stall with a captured buffer
    ex_to_mem_bus = mk_load(MEM_OP_LW, 32'h500, 5'd10, 32'h0000_3000);
    cycle();
    data_sram_rdata = 32'hCAFE_F00D;
    stall = 6'b011111;
    cycle();
    data_sram_rdata = 32'h0BAD_0BAD;
    #1;
    chk("rstmid_valid_pre", 70'(dut.rbuf_valid_q), 70'h1);
    chk("rstmid_wdata_pre", 70'(mem_to_wb_bus[31:0]), 70'hCAFE_F00D);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("rstmid_wb", 70'(mem_to_wb_bus), 70'h0);
    chk("rstmid_id", 70'(mem_to_id_bus), 70'h0);
    chk("rstmid_isload", 70'(mem_is_load), 70'h0);
    chk("rstmid_valid", 70'(dut.rbuf_valid_q), 70'h0);
    stall = 6'b000000;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have port: clk  input  1  pipeline clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: stall  input  6  pipeline stall vector, bit i = 1 means stage i stops; this block reads stall[3] (own input register) and stall[4] (writeback register).
REQ-004 SHALL have port: ex_to_mem_bus  input  80  fields: [79:76] mem_op, [75:44] pc, [43] data_ram_en, [42:39] data_ram_wen, [38] sel_rf_res, [37] rf_we, [36:32] rf_waddr, [31:0] ex_result.
REQ-005 SHALL have port: data_sram_rdata  input  32  synchronous SRAM read data, valid the cycle after the EX-stage request.
REQ-006 SHALL have port: mem_to_wb_bus  output  70  fields: [69:38] pc, [37] rf_we, [36:32] rf_waddr, [31:0] rf_wdata.
REQ-007 SHALL have port: mem_to_id_bus  output  38  forwarding: [37] rf_we, [36:32] rf_waddr, [31:0] rf_wdata.
REQ-008 SHALL have port: mem_is_load  output  1  current instruction is a load (hazard detection).

Function
REQ-009 SHALL hold an 80-bit input register bus_r: on rst cleared; else if stall[3]=1 and stall[4]=0 cleared (bubble); else if stall[3]=0 loaded from ex_to_mem_bus; else held.
REQ-010 SHALL classify the held instruction as a load when data_ram_en=1, data_ram_wen=4'b0000 and sel_rf_res=1.
REQ-011 SHALL decode mem_op: 4'b1111 LW, 4'b0001 LB, 4'b0010 LBU, 4'b0011 LH, 4'b0100 LHU; any other value with a load SHALL be treated as LW.
REQ-012 SHALL select the byte for LB/LBU by ex_result[1:0] (00 -> [7:0], 01 -> [15:8], 10 -> [23:16], 11 -> [31:24]); LB sign-extends, LBU zero-extends to 32 bits.
REQ-013 SHALL select the halfword for LH/LHU by ex_result[1] (0 -> [15:0], 1 -> [31:16]); LH sign-extends, LHU zero-extends; ex_result[0] ignored (no alignment exception).
REQ-014 SHALL set rf_wdata = extracted load data for loads, else ex_result.
REQ-015 SHALL hold a read-data buffer: rbuf (32 bits) plus rbuf_valid flag. When rbuf_valid=0 and stall[4]=1 with a load in the stage, capture data_sram_rdata into rbuf and set rbuf_valid=1.
REQ-016 SHALL use rbuf in place of data_sram_rdata whenever rbuf_valid=1.
REQ-017 SHALL clear rbuf_valid on any cycle stall[3]=0 or stall[4]=0 (instruction leaves or is replaced); clearing takes priority over capture.
REQ-018 SHALL drive mem_to_wb_bus and mem_to_id_bus combinationally from bus_r and rf_wdata (zero added latency beyond bus_r).
REQ-019 SHALL drive mem_to_id_bus rf_we=0 when bus_r holds a bubble (all-zero register gives rf_we=0 by construction).
REQ-020 SHALL assert mem_is_load combinationally per REQ-010.

Reset
REQ-021 SHALL, on rst, clear bus_r, rbuf and rbuf_valid in the same edge; all outputs SHALL read zero the cycle after rst is sampled high.
REQ-022 SHALL give rst priority over every stall and capture condition, including reset mid-stall with rbuf_valid=1.

Structure
REQ-023 SHALL take bus widths (EX_TO_MEM_WD=80, MEM_TO_WB_WD=70, MEM_TO_ID_FW=38), StallBus=6, Stop/NoStop and the mem_op encodings from the shared defines header.
REQ-024 SHALL contain one sub-module, load_align, holding the combinational extraction of REQ-011..REQ-014; all state stays in mem_stage.

Verification
REQ-025 SHALL test LW: ex_result=0x1000, rdata=0x8081_7F01, no stall -> rf_wdata=0x8081_7F01, rf_we=1.
REQ-026 SHALL test LB/LBU at offset 3: rdata=0x80xx_xxxx -> LB gives 0xFFFF_FF80, LBU gives 0x0000_0080; LH at offset 2 with rdata=0x8001_xxxx -> 0xFFFF_8001.
REQ-027 SHALL test stall hold: load with rdata=0x1234_5678, stall[4]=1 for 3 cycles while rdata changes to 0xDEAD_BEEF -> rf_wdata stays 0x1234_5678; rbuf_valid clears after release.
REQ-028 SHALL test bubble: stall=6'b001111 for one cycle -> next cycle mem_to_wb_bus=0, mem_to_id_bus rf_we=0.
REQ-029 SHALL test non-load pass-through: ALU result 0x0000_002A to r5 -> mem_to_wb_bus rf_waddr=5, rf_wdata=0x2A, mem_is_load=0.
REQ-030 SHALL test reset mid-stall: rbuf_valid=1, rst high one cycle -> all outputs zero, rbuf_valid=0 the next cycle.
